// File: rtl/profile_ci_multi.sv
// Multi-channel performance-counter custom instruction: programmable event sources, preload, coherent hi/lo read.
// Optional sticky overflow register is enabled by defining PROFILE_CI_OVERFLOW_EN.
module profile_ci_multi #(
    parameter logic [7:0]  customId      = 8'd8,
    parameter int unsigned NR_COUNTERS   = 8,
    parameter int unsigned COUNTER_WIDTH = 48,
    parameter int unsigned EXT_EVENTS    = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [7:0]            ciN,
    input  logic [31:0]           valueA,
    input  logic [31:0]           valueB,
    input  logic                  stall,
    input  logic                  busIdle,
    input  logic [EXT_EVENTS-1:0] events,
    output logic                  done,
    output logic [31:0]           result
);

    localparam int unsigned W = COUNTER_WIDTH;
    localparam int unsigned N = NR_COUNTERS;

    localparam logic [3:0] OP_CTRL  = 4'd0;
    localparam logic [3:0] OP_SHDW  = 4'd1;
    localparam logic [3:0] OP_SEL   = 4'd2;
    localparam logic [3:0] OP_OVFRD = 4'd3;
    localparam logic [3:0] OP_OVFCL = 4'd4;
    localparam logic [3:0] OP_LDLO  = 4'd5;
    localparam logic [3:0] OP_LDHI  = 4'd6;

    logic [W-1:0]  cnt_q [N];
    logic [W-1:0]  cnt_d [N];
    logic [3:0]    sel_q [N];
    logic [3:0]    sel_d [N];
    logic [N-1:0]  en_q, en_d;
    logic [31:0]   shadow_q, shadow_d;
    logic [N-1:0]  ev_c, ovr_c;
    logic [63:0]   rd64, ld64;
    logic [3:0]    rd_sel, idx, op;
    logic          hit, cmd;

    assign hit  = start & (ciN == customId);
    assign idx  = valueA[3:0];
    assign op   = valueA[7:4];
    assign cmd  = hit & (32'(idx) < N);
    assign done = hit;

    // Per-counter event source decode
    always_comb begin : event_mux
        ev_c = '0;
        for (int unsigned c = 0; c < N; c++) begin
            case (sel_q[c])
                4'd0:    ev_c[c] = 1'b1;
                4'd1:    ev_c[c] = stall;
                4'd2:    ev_c[c] = busIdle;
                4'd3:    ev_c[c] = ~stall & ~busIdle;
                default: begin
                    for (int unsigned k = 0; k < EXT_EVENTS; k++) begin
                        if (sel_q[c] == 4'(4 + k)) ev_c[c] = events[k];
                    end
                end
            endcase
        end
    end

    // Addressed counter/select readout and preload value
    always_comb begin : read_mux
        rd64   = '0;
        rd_sel = '0;
        for (int unsigned c = 0; c < N; c++) begin
            if (idx == 4'(c)) begin
                rd64   = 64'(cnt_q[c]);
                rd_sel = sel_q[c];
            end
        end
        ld64 = rd64;
        if (op == OP_LDHI) ld64[63:32] = valueB;
        else               ld64[31:0]  = valueB;
    end

    // Counting plus command side effects; clear/load overrides the increment
    always_comb begin : next_state
        shadow_d = shadow_q;
        en_d     = en_q;
        ovr_c    = '0;
        for (int unsigned c = 0; c < N; c++) begin
            cnt_d[c] = cnt_q[c];
            sel_d[c] = sel_q[c];
            if (en_q[c] && ev_c[c]) cnt_d[c] = cnt_q[c] + W'(1);
            if (cmd && op == OP_CTRL) begin
                if (valueB[8+c])      en_d[c] = 1'b0;
                else if (valueB[c])   en_d[c] = 1'b1;
                if (valueB[16+c]) begin
                    cnt_d[c] = '0;
                    ovr_c[c] = 1'b1;
                end
            end
            if (cmd && idx == 4'(c)) begin
                if (op == OP_LDLO || op == OP_LDHI) begin
                    cnt_d[c] = W'(ld64);
                    ovr_c[c] = 1'b1;
                end
                if (op == OP_SEL) sel_d[c] = valueB[3:0];
            end
        end
        if (cmd && op == OP_CTRL) shadow_d = rd64[63:32];
    end

`ifdef PROFILE_CI_OVERFLOW_EN
    logic [N-1:0] ovf_q, ovf_d;

    // Wrap sets the sticky bit and wins over a same-edge clear
    always_comb begin : ovf_next
        ovf_d = ovf_q;
        if (cmd && op == OP_OVFCL) ovf_d = ovf_q & ~valueB[N-1:0];
        for (int unsigned c = 0; c < N; c++) begin
            if (en_q[c] && ev_c[c] && !ovr_c[c] && (&cnt_q[c])) ovf_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) ovf_q <= '0;
        else        ovf_q <= ovf_d;
    end

    logic [31:0] ovf_rd_c;
    assign ovf_rd_c = 32'(ovf_q);
`else
    logic [31:0] ovf_rd_c;
    logic        unused_ovr;
    assign ovf_rd_c   = '0;
    assign unused_ovr = ^ovr_c;
`endif

    logic unused_va;
    assign unused_va = ^valueA[31:8];

    always_comb begin : result_mux
        result = '0;
        if (cmd) begin
            case (op)
                OP_CTRL:  result = rd64[31:0];
                OP_SHDW:  result = shadow_q;
                OP_SEL:   result = 32'(rd_sel);
                OP_OVFRD: result = ovf_rd_c;
                default:  result = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            en_q     <= '0;
            shadow_q <= '0;
            for (int unsigned c = 0; c < N; c++) begin
                cnt_q[c] <= '0;
                sel_q[c] <= (c <= 3) ? 4'(c) : 4'd0;
            end
        end else begin
            en_q     <= en_d;
            shadow_q <= shadow_d;
            for (int unsigned c = 0; c < N; c++) begin
                cnt_q[c] <= cnt_d[c];
                sel_q[c] <= sel_d[c];
            end
        end
    end

endmodule

// File: tb/tb_profile_ci_multi.sv
// Scoreboard bench for profile_ci_multi: three instances (W=48, W=8, W=40) sharing all inputs except start.
module tb_profile_ci_multi;

`ifdef PROFILE_CI_OVERFLOW_EN
    localparam logic [31:0] OVF_EXP = 32'd1;
`else
    localparam logic [31:0] OVF_EXP = 32'd0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic [2:0]  start_v;
    logic [7:0]  ciN;
    logic [31:0] valueA, valueB;
    logic        stall, busIdle;
    logic [3:0]  events;
    logic        done0, done1, done2;
    logic [31:0] res0, res1, res2;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          dut;
        logic        dn;
        logic [31:0] r;
        string       tag;
    } exp_t;
    exp_t sb[$];

    always #5 clock = ~clock;

    profile_ci_multi u_d48 (
        .clock(clock), .reset(reset), .start(start_v[0]), .ciN(ciN), .valueA(valueA), .valueB(valueB),
        .stall(stall), .busIdle(busIdle), .events(events), .done(done0), .result(res0));

    profile_ci_multi #(.COUNTER_WIDTH(8)) u_d8 (
        .clock(clock), .reset(reset), .start(start_v[1]), .ciN(ciN), .valueA(valueA), .valueB(valueB),
        .stall(stall), .busIdle(busIdle), .events(events), .done(done1), .result(res1));

    profile_ci_multi #(.COUNTER_WIDTH(40)) u_d40 (
        .clock(clock), .reset(reset), .start(start_v[2]), .ciN(ciN), .valueA(valueA), .valueB(valueB),
        .stall(stall), .busIdle(busIdle), .events(events), .done(done2), .result(res2));

    task automatic issue(input int d, input logic [7:0] id, input logic [3:0] idx, input logic [3:0] op,
                         input logic [31:0] b, input logic exp_dn, input logic [31:0] exp_r, input string tag);
        @(negedge clock);
        start_v    = 3'b000;
        start_v[d] = 1'b1;
        ciN        = id;
        valueA     = {24'b0, op, idx};
        valueB     = b;
        sb.push_back('{d, exp_dn, exp_r, tag});
        @(posedge clock);
    endtask

    task automatic cmd(input int d, input logic [3:0] idx, input logic [3:0] op, input logic [31:0] b,
                       input logic [31:0] exp_r, input string tag);
        issue(d, 8'd8, idx, op, b, 1'b1, exp_r, tag);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clock);
            start_v = 3'b000;
            @(posedge clock);
        end
    endtask

    // Scoreboard: each driven command is popped and compared mid-cycle; quiet cycles must show done low
    initial begin
        exp_t        e;
        logic        dn;
        logic [31:0] r;
        forever begin
            @(negedge clock);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                case (e.dut)
                    0:       begin dn = done0; r = res0; end
                    1:       begin dn = done1; r = res1; end
                    default: begin dn = done2; r = res2; end
                endcase
                total++;
                if (dn !== e.dn || r !== e.r) begin
                    bad++;
                    $display("FAIL %s: got done=%0b result=%h, want done=%0b result=%h", e.tag, dn, r, e.dn, e.r);
                end
            end else begin
                total++;
                if ({done0, done1, done2} !== 3'b000) begin
                    bad++;
                    $display("FAIL idle_done: got %b, want 000", {done0, done1, done2});
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clock);
        #1;
        total++;
        if ({done0, done1, done2} !== 3'b000 || res0 !== 32'h0 || res1 !== 32'h0 || res2 !== 32'h0) begin
            bad++;
            $display("FAIL reset_idle: got done=%b r0=%h r1=%h r2=%h, want all 0", {done0, done1, done2}, res0, res1, res2);
        end
        cmd(0, 4'd0, 4'd0, 32'h0, 32'h0, "reset_hit_read");
        idle(1);
        @(negedge clock);
        reset = 1'b1;
        idle(1);
    endtask

    task automatic test_wrong_id();
        for (int i = 0; i < 5; i++) issue(0, 8'h11, 4'd0, 4'd0, 32'h1, 1'b0, 32'h0, "wrong_id");
        cmd(0, 4'd0, 4'd0, 32'h0, 32'h0, "wrong_id_cnt0");
        idle(1);
    endtask

    task automatic test_count_clear();
        cmd(0, 4'd0, 4'd0, 32'h1, 32'h0, "en0");
        idle(10);
        cmd(0, 4'd0, 4'd0, 32'h0, 32'd10, "cnt10");
        cmd(0, 4'd0, 4'd0, 32'h10101, 32'd11, "en_dis_clr");
        idle(2);
        cmd(0, 4'd0, 4'd0, 32'h0, 32'h0, "cleared_disabled");
        idle(1);
    endtask

    task automatic test_event_sel();
        cmd(0, 4'd4, 4'd2, 32'h4, 32'h0, "sel4_old");
        cmd(0, 4'd4, 4'd2, 32'h4, 32'h4, "sel4_readback");
        cmd(0, 4'd4, 4'd0, 32'h10, 32'h0, "en4");
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            start_v   = 3'b000;
            events[0] = 1'b1;
            stall     = ~stall;
            @(negedge clock);
            events[0] = 1'b0;
            stall     = ~stall;
            @(negedge clock);
            stall     = ~stall;
        end
        cmd(0, 4'd4, 4'd0, 32'h0, 32'd3, "cnt4_events");
        idle(1);
        stall = 1'b0;
    endtask

    task automatic test_bounds();
        cmd(0, 4'd3, 4'd2, 32'h3, 32'h3, "sel3_reset");
        cmd(0, 4'd9, 4'd0, 32'h00FF00FF, 32'h0, "oob_index");
        cmd(0, 4'd8, 4'd2, 32'h1, 32'h0, "oob_sel8");
        cmd(0, 4'd0, 4'd7, 32'hFF, 32'h0, "bad_opcode");
        stall = 1'b1;
        idle(3);
        cmd(0, 4'd1, 4'd0, 32'h0, 32'h0, "oob_no_enable");
        stall = 1'b0;
        idle(1);
    endtask

    task automatic test_wrap();
        cmd(1, 4'd0, 4'd0, 32'h1, 32'h0, "w8_en");
        idle(255);
        cmd(1, 4'd0, 4'd0, 32'h0, 32'hFF, "w8_allones");
        cmd(1, 4'd0, 4'd0, 32'h100, 32'h0, "w8_wrapped");
        cmd(1, 4'd0, 4'd3, 32'h0, OVF_EXP, "w8_ovf_set");
        cmd(1, 4'd0, 4'd4, 32'h1, 32'h0, "w8_ovf_clr");
        cmd(1, 4'd0, 4'd3, 32'h0, 32'h0, "w8_ovf_zero");
        idle(1);
        cmd(1, 4'd0, 4'd0, 32'h0, 32'h1, "w8_after_disable");
        idle(1);
    endtask

    task automatic test_back_to_back_coherent();
        cmd(2, 4'd0, 4'd6, 32'h0, 32'h0, "c40_load_hi");
        cmd(2, 4'd0, 4'd5, 32'hFFFFFFFF, 32'h0, "c40_load_lo");
        cmd(2, 4'd0, 4'd0, 32'h1, 32'hFFFFFFFF, "c40_enable");
        cmd(2, 4'd0, 4'd0, 32'h0, 32'hFFFFFFFF, "c40_read_lo");
        cmd(2, 4'd0, 4'd1, 32'h0, 32'h0, "c40_shadow");
        cmd(2, 4'd0, 4'd0, 32'h100, 32'h1, "c40_read_lo2");
        cmd(2, 4'd0, 4'd1, 32'h0, 32'h1, "c40_shadow2");
        idle(1);
    endtask

    task automatic test_async_reset();
        cmd(0, 4'd0, 4'd0, 32'h1, 32'h0, "ar_enable");
        idle(5);
        @(posedge clock);
        #2;
        reset = 1'b0;
        cmd(0, 4'd0, 4'd0, 32'h0, 32'h0, "ar_cnt_in_reset");
        cmd(0, 4'd4, 4'd0, 32'h0, 32'h0, "ar_cnt4_in_reset");
        idle(1);
        @(negedge clock);
        reset = 1'b1;
        idle(3);
        cmd(0, 4'd0, 4'd0, 32'h0, 32'h0, "ar_not_counting");
        cmd(1, 4'd0, 4'd3, 32'h0, 32'h0, "ar_ovf_zero");
        cmd(0, 4'd2, 4'd2, 32'h2, 32'h2, "ar_sel2");
        idle(1);
    endtask

    initial begin
        reset   = 1'b0;
        start_v = 3'b000;
        ciN     = 8'h0;
        valueA  = 32'h0;
        valueB  = 32'h0;
        stall   = 1'b0;
        busIdle = 1'b0;
        events  = 4'h0;
        test_reset();
        test_wrong_id();
        test_count_clear();
        test_event_sel();
        test_bounds();
        test_wrap();
        test_back_to_back_coherent();
        test_async_reset();
        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
